// File: rtl/floating_point_divider_if.sv
// Request/response bundle for floating_point_divider: operands and start in,
// quotient with busy/done/div_by_zero status out.
interface floating_point_divider_if;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] result;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  modport master (
    output start, A, B,
    input  result, busy, done, div_by_zero
  );

  modport slave (
    input  start, A, B,
    output result, busy, done, div_by_zero
  );
endinterface

// File: rtl/floating_point_divider.sv
// IEEE-754 single-precision divider: 26-cycle restoring mantissa divide, one NORM cycle.
// Define FP_DIV_ROUND_EN for round-to-nearest-even; otherwise the quotient is truncated.
module floating_point_divider (
  input  logic                     clk,
  input  logic                     rst_n,
  floating_point_divider_if.slave  bus
);

  localparam int unsigned MW = 24;
  localparam int unsigned QW = 26;
  localparam int unsigned EW = 10;
  localparam int unsigned CW = 5;
  localparam int unsigned FW = 23;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;

  state_t                state;
  logic [MW-1:0]         m_b;
  logic [QW-1:0]         rem;
  logic [QW-1:0]         q;
  logic signed [EW-1:0]  exp_q;
  logic                  sign_q;
  logic [CW-1:0]         cnt;

  logic [31:0]           result_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  dbz_q;

  assign bus.result      = result_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;

  // Operand classification at the accepting edge; denormals count as zero.
  logic [7:0]           exp_a_c, exp_b_c;
  logic                 sign_c;
  logic                 a_zero_c, b_zero_c, a_spec_c, b_spec_c;
  logic signed [EW-1:0] exp_diff_c;

  assign exp_a_c    = bus.A[30:23];
  assign exp_b_c    = bus.B[30:23];
  assign sign_c     = bus.A[31] ^ bus.B[31];
  assign a_zero_c   = (exp_a_c == 8'd0);
  assign b_zero_c   = (exp_b_c == 8'd0);
  assign a_spec_c   = (exp_a_c == 8'hFF);
  assign b_spec_c   = (exp_b_c == 8'hFF);
  assign exp_diff_c = $signed({2'b00, exp_a_c}) - $signed({2'b00, exp_b_c}) + 10'sd127;

  // One restoring-division step: subtract when the partial remainder covers mB.
  logic          rem_ge;
  logic [QW-1:0] rem_sub;

  assign rem_ge  = (rem >= QW'(m_b));
  assign rem_sub = rem_ge ? (rem - QW'(m_b)) : rem;

  // Normalization, optional rounding and range check of the finished quotient.
  logic [FW-1:0]        frac_n, frac_r;
  logic                 guard, sticky;
  logic signed [EW-1:0] exp_n, exp_r;
  logic [31:0]          norm_result;

  always_comb begin
    frac_n = q[23:1];
    guard  = q[0];
    sticky = (rem != '0);
    exp_n  = exp_q - 10'sd1;
    if (q[25]) begin
      frac_n = q[24:2];
      guard  = q[1];
      sticky = q[0] | (rem != '0);
      exp_n  = exp_q;
    end
  end

`ifdef FP_DIV_ROUND_EN
  logic          round_up;
  logic [FW:0]   frac_sum;

  assign round_up = guard & (sticky | frac_n[0]);
  assign frac_sum = {1'b0, frac_n} + (FW+1)'(round_up);

  // A carry out of the fraction leaves it all-zero and bumps the exponent.
  always_comb begin
    frac_r = frac_sum[FW-1:0];
    exp_r  = exp_n;
    if (frac_sum[FW]) exp_r = exp_n + 10'sd1;
  end
`else
  logic unused_round_bits;

  assign unused_round_bits = guard ^ sticky;
  assign frac_r = frac_n;
  assign exp_r  = exp_n;
`endif

  always_comb begin
    norm_result = {sign_q, exp_r[7:0], frac_r};
    if (exp_r > 10'sd254)
      norm_result = {sign_q, 8'hFF, 23'd0};
    else if (exp_r < 10'sd1)
      norm_result = {sign_q, 31'd0};
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      m_b      <= '0;
      rem      <= '0;
      q        <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      cnt      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            sign_q <= sign_c;
            if (a_spec_c || b_spec_c || (a_zero_c && b_zero_c)) begin
              result_q <= QNAN;
              dbz_q    <= 1'b0;
              done_q   <= 1'b1;
              state    <= DONE;
            end else if (b_zero_c) begin
              result_q <= {sign_c, 8'hFF, 23'd0};
              dbz_q    <= 1'b1;
              done_q   <= 1'b1;
              state    <= DONE;
            end else if (a_zero_c) begin
              result_q <= {sign_c, 31'd0};
              dbz_q    <= 1'b0;
              done_q   <= 1'b1;
              state    <= DONE;
            end else begin
              rem   <= QW'({1'b1, bus.A[22:0]});
              m_b   <= {1'b1, bus.B[22:0]};
              q     <= '0;
              cnt   <= '0;
              exp_q <= exp_diff_c;
              state <= CALC;
            end
          end
        end
        CALC: begin
          q   <= {q[QW-2:0], rem_ge};
          rem <= {rem_sub[QW-2:0], 1'b0};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(QW-1)) state <= NORM;
        end
        NORM: begin
          result_q <= norm_result;
          dbz_q    <= 1'b0;
          done_q   <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_floating_point_divider.sv
// Directed self-checking bench for floating_point_divider: special cases,
// normal quotients, latency, reset abort and start-while-busy rejection.
module tb_floating_point_divider;

  logic clk;
  logic rst_n;
  int   checks;
  int   fails;

  floating_point_divider_if bus();

  floating_point_divider dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Issue one operation from a negedge, then measure done latency and the outputs.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_dbz, input int exp_lat);
    int cyc;
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.A     = 32'hFFFF_FFFF;
    bus.B     = 32'hFFFF_FFFF;
    @(negedge clk);
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_result"}, bus.result, exp_res);
    check({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(exp_dbz));
    check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd1);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_held"}, bus.result, exp_res);
  endtask

  initial begin
    int pulses;
    int first_done;
    logic [31:0] third;

    checks    = 0;
    fails     = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = 32'd0;
    bus.B     = 32'd0;

    repeat (3) @(negedge clk);
    check("rst_result", bus.result, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_dbz", 32'(bus.div_by_zero), 32'd0);

    rst_n = 1'b1;
    run_op("six_by_two", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 28);

`ifdef FP_DIV_ROUND_EN
    third = 32'h3EAA_AAAB;
`else
    third = 32'h3EAA_AAAA;
`endif
    run_op("one_by_three", 32'h3F80_0000, 32'h4040_0000, third, 1'b0, 28);
    run_op("neg_by_zero", 32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1'b1, 1);
    run_op("dbz_cleared", 32'hC000_0000, 32'h3F00_0000, 32'hC080_0000, 1'b0, 28);
    run_op("zero_by_zero", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 1);
    run_op("neg_zero", 32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 1'b0, 1);
    run_op("overflow", 32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 1'b0, 28);
    run_op("underflow", 32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 1'b0, 28);
    run_op("inf_operand", 32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 1);
    run_op("denorm_a", 32'h8000_0001, 32'h3F80_0000, 32'h8000_0000, 1'b0, 1);

    // Reset in the middle of a divide aborts it without a done pulse.
    bus.A     = 32'h40C0_0000;
    bus.B     = 32'h4000_0000;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    pulses = 0;
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) pulses++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_result", bus.result, 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_dbz", 32'(bus.div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) pulses++;
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    run_op("one_by_one", 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 28);

    // Starts while busy (mid-divide and in the DONE cycle) must be ignored.
    bus.A     = 32'h40C0_0000;
    bus.B     = 32'h4000_0000;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    pulses     = 0;
    first_done = 0;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        pulses++;
        if (first_done == 0) first_done = k;
      end
      if (k == 5 || k == 28) begin
        bus.A     = 32'h3F80_0000;
        bus.B     = 32'h4040_0000;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
    end
    check("busy_start_pulses", 32'(pulses), 32'd1);
    check("busy_start_latency", 32'(first_done), 32'd28);
    check("busy_start_result", bus.result, 32'h4040_0000);
    check("busy_start_idle", 32'(bus.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
